mmio_timer_responder: RTL and testbench



---
 rtl/mmio_timer_responder.sv | 170 +++++++++++++++++
 tb/tb_mmio_timer_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped prescaled 32-bit timer on the CPU memory bus.
// Decodes a 32-byte window at BASE_ADDR and returns registered read data one cycle
// after the access, matching the synchronous read latency of the main memory block.
// Ports:
//   Clk      - rising-edge clock
//   reset_l  - asynchronous active-low reset
//   Address  - CPU byte address (word offset taken from [4:2])
//   Wr       - 1 = write, 0 = read
//   Datain   - write data
//   Dataout  - registered read data (0 when the previous access was not a window read)
//   Hit      - registered: previous access was a read inside the window
//   Irq      - registered interrupt request (MATCH & IE)
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0F00,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        reset_l,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Hit,
    output logic        Irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 3;

    localparam logic [OW-1:0] OFF_CTRL     = OW'(0);
    localparam logic [OW-1:0] OFF_COUNT    = OW'(1);
    localparam logic [OW-1:0] OFF_COMPARE  = OW'(2);
    localparam logic [OW-1:0] OFF_STATUS   = OW'(3);
    localparam logic [OW-1:0] OFF_PRESCALE = OW'(4);

    // Architectural state
    logic          en_q, auto_q, ie_q, match_q;
    logic [DW-1:0] count_q, compare_q, prescale_q, pcnt_q;

    // Next-state values
    logic          en_d, auto_d, ie_d, match_d, irq_d;
    logic [DW-1:0] count_d, compare_d, prescale_d, pcnt_d;

    // Bus decode
    logic          in_win_c, wr_c, rd_c;
    logic [OW-1:0] offset_c;
    logic          wr_ctrl_c, wr_count_c, wr_compare_c, wr_status_c, wr_prescale_c;
    logic [DW-1:0] rdata_c;
    logic          tick_c, match_evt_c;
    logic          addr_unused_c;

    assign in_win_c = (Address[31:5] == BASE_ADDR[31:5]);
    assign offset_c = Address[4:2];
    assign wr_c     = in_win_c & Wr;
    assign rd_c     = in_win_c & ~Wr;

    // Byte-lane bits carry no meaning: every access is a full word.
    assign addr_unused_c = ^Address[1:0];

    assign wr_ctrl_c     = wr_c & (offset_c == OFF_CTRL);
    assign wr_count_c    = wr_c & (offset_c == OFF_COUNT);
    assign wr_compare_c  = wr_c & (offset_c == OFF_COMPARE);
    assign wr_status_c   = wr_c & (offset_c == OFF_STATUS);
    assign wr_prescale_c = wr_c & (offset_c == OFF_PRESCALE);

    // Prescaler tick and compare match use pre-edge register values.
    assign tick_c      = en_q & (pcnt_q == prescale_q);
    assign match_evt_c = tick_c & (count_q == compare_q);

    // Read mux over current (pre-update) register contents
    always_comb begin
        rdata_c = '0;
        case (offset_c)
            OFF_CTRL:     rdata_c = {29'b0, ie_q, auto_q, en_q};
            OFF_COUNT:    rdata_c = count_q;
            OFF_COMPARE:  rdata_c = compare_q;
            OFF_STATUS:   rdata_c = {31'b0, match_q};
            OFF_PRESCALE: rdata_c = prescale_q;
            default:      rdata_c = '0;
        endcase
    end

    // Next-state: timer events first, then bus writes so that writes take priority,
    // except that a match event beats a same-edge STATUS clear.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        match_d    = match_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;

        if (!en_q || tick_c) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + DW'(1);
        end
        if (wr_ctrl_c || wr_prescale_c) begin
            pcnt_d = '0;
        end

        if (tick_c) begin
            if (match_evt_c) begin
                if (auto_q) begin
                    count_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + DW'(1);
            end
        end

        if (wr_ctrl_c) begin
            en_d   = Datain[0];
            auto_d = Datain[1];
            ie_d   = Datain[2];
        end
        if (wr_count_c) begin
            count_d = Datain;
        end
        if (wr_compare_c) begin
            compare_d = Datain;
        end
        if (wr_prescale_c) begin
            prescale_d = Datain;
        end

        if (wr_status_c && Datain[0]) begin
            match_d = 1'b0;
        end
        if (match_evt_c) begin
            match_d = 1'b1;
        end

        irq_d = match_d & ie_d;
    end

    // State and output registers
    always_ff @(posedge Clk or negedge reset_l) begin
        if (!reset_l) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            match_q    <= 1'b0;
            count_q    <= '0;
            compare_q  <= RESET_COMPARE;
            prescale_q <= '0;
            pcnt_q     <= '0;
            Dataout    <= '0;
            Hit        <= 1'b0;
            Irq        <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            Dataout    <= rd_c ? rdata_c : '0;
            Hit        <= rd_c;
            Irq        <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Testbench for mmio_timer_responder: directed bus traffic with a cycle-stamped
// expectation queue checked by an independent negedge monitor.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_0F00;

    localparam logic [2:0] R_CTRL     = 3'd0;
    localparam logic [2:0] R_COUNT    = 3'd1;
    localparam logic [2:0] R_COMPARE  = 3'd2;
    localparam logic [2:0] R_STATUS   = 3'd3;
    localparam logic [2:0] R_PRESCALE = 3'd4;

    logic        Clk = 1'b0;
    logic        reset_l;
    logic [31:0] Address;
    logic        Wr;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Hit;
    logic        Irq;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          cyc;
        bit          chk_bus;
        bit          exp_hit;
        logic [31:0] exp_data;
        bit          chk_irq;
        bit          exp_irq;
        string       name;
    } exp_t;

    exp_t sb[$];

    mmio_timer_responder #(
        .BASE_ADDR    (32'h0000_0F00),
        .RESET_COMPARE(32'hFFFF_FFFF)
    ) dut (
        .Clk    (Clk),
        .reset_l(reset_l),
        .Address(Address),
        .Wr     (Wr),
        .Datain (Datain),
        .Dataout(Dataout),
        .Hit    (Hit),
        .Irq    (Irq)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].chk_bus) begin
                    check({sb[i].name, "_hit"}, 32'(Hit), 32'(sb[i].exp_hit));
                    check({sb[i].name, "_data"}, Dataout, sb[i].exp_data);
                end
                if (sb[i].chk_irq) begin
                    check({sb[i].name, "_irq"}, 32'(Irq), 32'(sb[i].exp_irq));
                end
                sb.delete(i);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge Clk);
        Address = a;
        Wr      = w;
        Datain  = d;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        drive(BASE + 32'({off, 2'b00}), 1'b1, d);
    endtask

    task automatic rd_addr(input logic [31:0] a, input bit hit, input logic [31:0] data,
                           input string name);
        exp_t e;
        drive(a, 1'b0, 32'h0);
        e.cyc      = cyc + 1;
        e.chk_bus  = 1'b1;
        e.exp_hit  = hit;
        e.exp_data = data;
        e.chk_irq  = 1'b0;
        e.exp_irq  = 1'b0;
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] data, input string name);
        rd_addr(BASE + 32'({off, 2'b00}), 1'b1, data, name);
    endtask

    task automatic exp_irq(input int c, input bit v, input string name);
        exp_t e;
        e.cyc      = c;
        e.chk_bus  = 1'b0;
        e.exp_hit  = 1'b0;
        e.exp_data = 32'h0;
        e.chk_irq  = 1'b1;
        e.exp_irq  = v;
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        exp_t e;
        int   c;

        // Reset state
        reset_l = 1'b0;
        Address = 32'h0;
        Wr      = 1'b0;
        Datain  = 32'h0;
        repeat (2) @(negedge Clk);
        e.cyc = cyc + 1; e.chk_bus = 1'b1; e.exp_hit = 1'b0; e.exp_data = 32'h0;
        e.chk_irq = 1'b1; e.exp_irq = 1'b0; e.name = "in_reset";
        sb.push_back(e);
        @(negedge Clk);
        reset_l = 1'b1;

        // Run the counter with a window read held, then reset asynchronously mid-cycle
        wr(R_CTRL, 32'h1);
        drive(BASE + 32'h4, 1'b0, 32'h0);
        drive(BASE + 32'h4, 1'b0, 32'h0);
        #1 reset_l = 1'b0;
        #1;
        check("async_rst_hit", 32'(Hit), 32'h0);
        check("async_rst_data", Dataout, 32'h0);
        Address = 32'h0;
        repeat (2) @(negedge Clk);
        reset_l = 1'b1;
        rd(R_COMPARE, 32'hFFFF_FFFF, "compare_rst");
        rd(R_CTRL, 32'h0, "ctrl_rst");
        rd(R_COUNT, 32'h0, "count_rst");
        rd(R_STATUS, 32'h0, "status_rst");
        rd(R_PRESCALE, 32'h0, "prescale_rst");
        rd(3'd5, 32'h0, "unmapped_f14");

        // Prescaled count: tick every 4 cycles, 10 ticks before the read edge
        wr(R_PRESCALE, 32'd3);
        wr(R_COMPARE, 32'd100);
        wr(R_CTRL, 32'h1);
        idle(40);
        rd(R_COUNT, 32'd10, "prescaled_count");
        rd_addr(32'h0000_0100, 1'b0, 32'h0, "outside_window");

        // Auto-reload with interrupt
        wr(R_CTRL, 32'h0);
        wr(R_COUNT, 32'h0);
        wr(R_STATUS, 32'h1);
        wr(R_PRESCALE, 32'h0);
        wr(R_COMPARE, 32'd5);
        wr(R_CTRL, 32'h7);
        c = cyc;
        exp_irq(c + 6, 1'b0, "irq_before_match");
        exp_irq(c + 7, 1'b1, "irq_on_match");
        exp_irq(c + 9, 1'b1, "irq_held");
        exp_irq(c + 10, 1'b0, "irq_cleared");
        exp_irq(c + 12, 1'b0, "irq_before_rematch");
        exp_irq(c + 13, 1'b1, "irq_rematch");
        idle(6);
        rd(R_COUNT, 32'h0, "auto_reload_count");
        rd(R_STATUS, 32'h1, "auto_match_set");
        wr(R_STATUS, 32'h1);
        idle(2);
        rd(R_STATUS, 32'h0, "status_w1c");
        rd(R_COUNT, 32'h0, "rematch_count");
        rd(R_STATUS, 32'h1, "rematch_status");
        wr(R_CTRL, 32'h0);

        // One-shot
        wr(R_STATUS, 32'h1);
        wr(R_COUNT, 32'h0);
        wr(R_COMPARE, 32'd2);
        wr(R_CTRL, 32'h1);
        c = cyc;
        exp_irq(c + 4, 1'b0, "oneshot_no_irq");
        idle(3);
        rd(R_CTRL, 32'h0, "oneshot_en_clear");
        rd(R_COUNT, 32'd2, "oneshot_count_hold");
        rd(R_STATUS, 32'h1, "oneshot_match");

        // Bus write to COUNT on a tick edge beats the increment
        wr(R_STATUS, 32'h1);
        wr(R_PRESCALE, 32'd1);
        wr(R_COMPARE, 32'h1000);
        wr(R_COUNT, 32'h50);
        wr(R_CTRL, 32'h1);
        idle(1);
        wr(R_COUNT, 32'h50);
        rd(R_COUNT, 32'h50, "count_write_wins");
        rd(R_COUNT, 32'h50, "count_before_tick");
        rd(R_COUNT, 32'h51, "count_after_tick");
        wr(R_CTRL, 32'h0);

        // Match event beats a same-edge STATUS clear
        wr(R_STATUS, 32'h1);
        wr(R_PRESCALE, 32'h0);
        wr(R_COUNT, 32'h0);
        wr(R_COMPARE, 32'd3);
        wr(R_CTRL, 32'h3);
        idle(3);
        wr(R_STATUS, 32'h1);
        rd(R_STATUS, 32'h1, "match_beats_clear");
        rd(R_COUNT, 32'h1, "reload_then_count");
        wr(R_CTRL, 32'h0);

        // CTRL write beats a same-edge one-shot EN clear
        wr(R_STATUS, 32'h1);
        wr(R_COUNT, 32'h0);
        wr(R_COMPARE, 32'd1);
        wr(R_CTRL, 32'h1);
        idle(1);
        wr(R_CTRL, 32'h5);
        rd(R_CTRL, 32'h5, "ctrl_write_wins");
        wr(R_CTRL, 32'h0);

        // Silent wrap from all-ones
        wr(R_STATUS, 32'h1);
        wr(R_COUNT, 32'hFFFF_FFFF);
        wr(R_COMPARE, 32'd10);
        wr(R_PRESCALE, 32'h0);
        wr(R_CTRL, 32'h1);
        wr(R_CTRL, 32'h0);
        rd(R_COUNT, 32'h0, "wrap_count");
        rd(R_STATUS, 32'h0, "wrap_no_match");

        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
